// File: rtl/board_drawer.sv
`default_nettype none
// ============================================================================
// Module  : board_drawer
// Purpose : Handshaked full-board redraw; walks 64 cells, one square per cell,
//           cursor cell outlined in red.
// Rev     : 1.0  initial release
// ============================================================================
module board_drawer #(
  parameter int CELL_PITCH = 13,
  parameter int DISK_SIZE  = 11,
  parameter int X0         = 8,
  parameter int Y0         = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] cursor_x,
  input  logic [2:0] cursor_y,
  input  logic       cursor_en,
  output logic [2:0] rd_x,
  output logic [2:0] rd_y,
  input  logic [1:0] rd_q,
  output logic [7:0] x_plot,
  output logic [6:0] y_plot,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int              PW     = $clog2(DISK_SIZE);
  localparam logic [PW-1:0]   c_PMAX = PW'(DISK_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [5:0]      r_cell;
  logic [PW-1:0]   r_px;
  logic [PW-1:0]   r_py;
  logic [1:0]      r_val;
  logic            r_curs;

  logic [2:0]      w_col;
  logic [2:0]      w_row;
  logic            w_edge;
  logic [7:0]      w_x;
  logic [6:0]      w_y;

  assign w_col = r_cell[2:0];
  assign w_row = r_cell[5:3];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cell  <= 6'd0;
      r_px    <= '0;
      r_py    <= '0;
      r_val   <= 2'd0;
      r_curs  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_cell  <= 6'd0;
            r_px    <= '0;
            r_py    <= '0;
          end
        end
        S_FETCH: begin
          // Cell contents and cursor match are frozen here for the whole square.
          r_val   <= rd_q;
          r_curs  <= cursor_en && (cursor_x == w_col) && (cursor_y == w_row);
          r_state <= S_DRAW;
        end
        S_DRAW: begin
          if (r_px == c_PMAX) begin
            r_px <= '0;
            if (r_py == c_PMAX) begin
              r_py <= '0;
              if (r_cell == 6'd63) begin
                r_state <= S_DONE;
              end else begin
                r_cell  <= r_cell + 6'd1;
                r_state <= S_FETCH;
              end
            end else begin
              r_py <= r_py + 1'b1;
            end
          end else begin
            r_px <= r_px + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign plot = (r_state == S_DRAW);
  assign rd_x = busy ? w_col : 3'd0;
  assign rd_y = busy ? w_row : 3'd0;

  // Sums formed at 9 bits; the parameter limits keep the result on screen.
  assign w_x = 8'(9'(X0) + 9'(w_col) * 9'(CELL_PITCH) + 9'(r_px));
  assign w_y = 7'(9'(Y0) + 9'(w_row) * 9'(CELL_PITCH) + 9'(r_py));
  assign w_edge = (r_px == '0) || (r_py == '0) || (r_px == c_PMAX) || (r_py == c_PMAX);

  assign x_plot = plot ? w_x : 8'd0;
  assign y_plot = plot ? w_y : 7'd0;

  always_comb begin
    colour = 3'b000;
    if (plot) begin
      if (r_curs && w_edge)  colour = 3'b100;
      else if (r_val == 2'd2) colour = 3'b000;
      else if (r_val == 2'd3) colour = 3'b111;
      else                    colour = 3'b010;
    end
  end

endmodule
`default_nettype wire
